// File: rtl/sha_pkg.sv
// ============================================================================
//  Module      : sha_pkg
//  Description : Shared SHA-2 types and constants for the padder and core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_OUT   = 2'd2,
        ST_EXTRA = 2'd3
    } state_t;

    localparam logic MODE_256 = 1'b0;
    localparam logic MODE_512 = 1'b1;

    localparam int BLK_BYTES_256 = 64;
    localparam int BLK_BYTES_512 = 128;
    localparam int LEN_BYTES_256 = 8;
    localparam int LEN_BYTES_512 = 16;
    localparam int FIT_BYTES_256 = BLK_BYTES_256 - LEN_BYTES_256;
    localparam int FIT_BYTES_512 = BLK_BYTES_512 - LEN_BYTES_512;

    localparam logic [255:0] H0_256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] H0_384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    function automatic int blk_bytes(input logic mode);
        return (mode == MODE_512) ? BLK_BYTES_512 : BLK_BYTES_256;
    endfunction

    function automatic int fit_bytes(input logic mode);
        return (mode == MODE_512) ? FIT_BYTES_512 : FIT_BYTES_256;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha_pad_mask.sv
// ============================================================================
//  Module      : sha_pad_mask
//  Description : Masks the final message word and inserts the 0x80 marker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_pad_mask #(
    parameter int WORD_W = 64
) (
    input  logic [WORD_W-1:0]           i_data,
    input  logic [$clog2(WORD_W/8):0]   i_bytes,
    output logic [WORD_W-1:0]           o_word,
    output logic                        o_spill
);

    localparam int c_nb = WORD_W / 8;
    localparam int c_bw = $clog2(c_nb) + 1;

    genvar i;
    generate
        for (i = 0; i < c_nb; i++) begin : g_byte
            assign o_word[WORD_W-1-8*i -: 8] =
                (c_bw'(i) <  i_bytes) ? i_data[WORD_W-1-8*i -: 8] :
                (c_bw'(i) == i_bytes) ? 8'h80 : 8'h00;
        end
    endgenerate

    // A full last word leaves no room for the marker inside this word.
    assign o_spill = (i_bytes >= c_bw'(c_nb));

endmodule

`default_nettype wire

// File: rtl/sha_msg_padder.sv
// ============================================================================
//  Module      : sha_msg_padder
//  Description : Streaming SHA-256 / SHA-384/512 message padder and blocker.
//                Optional macro SHA_PAD_OVF_EN adds the sticky len_ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha_msg_padder
    import sha_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int LEN_W  = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W-1:0]           in_data,
    input  logic                        in_last,
    input  logic [$clog2(WORD_W/8):0]   in_bytes,
    input  logic                        in_mode,
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [1023:0]               blk_data,
    output logic                        blk_last,
    output logic                        blk_mode
`ifdef SHA_PAD_OVF_EN
    ,
    output logic                        len_ovf
`endif
);

    localparam int c_wb        = WORD_W / 8;
    localparam int c_max_words = 1024 / WORD_W;
    localparam int c_widx_w    = $clog2(c_max_words) + 1;

    state_t                 r_state, w_state_nxt;
    logic [1023:0]          r_buf, w_buf_nxt;
    logic [c_widx_w-1:0]    r_widx, w_widx_nxt;
    logic [LEN_W-1:0]       r_len, w_len_nxt;
    logic                   r_mode, w_mode_nxt;
    logic                   r_blk_last, w_last_nxt;
    logic                   r_extra_pend, w_extra_nxt;
    logic                   r_marker_pend, w_marker_nxt;

    logic                   w_accept;
    logic                   w_cur_mode;
    logic [WORD_W-1:0]      w_masked;
    logic [WORD_W-1:0]      w_cur_word;
    logic                   w_spill;
    logic                   w_at_end;
    logic                   w_fits;
    logic [9:0]             w_used;
    logic [c_widx_w-1:0]    w_widx_inc;
    logic [LEN_W-1:0]       w_len_base, w_len_add, w_len_sum, w_field_src;
    logic [127:0]           w_len_field;
    logic [1023:0]          w_buf_word;
    logic [1023:0]          w_buf_extra;

    sha_pad_mask #(
        .WORD_W (WORD_W)
    ) u_mask (
        .i_data  (in_data),
        .i_bytes (in_bytes),
        .o_word  (w_masked),
        .o_spill (w_spill)
    );

    function automatic logic [1023:0] put_len(input logic [1023:0] b,
                                              input logic m,
                                              input logic [127:0] l);
        logic [1023:0] r;
        r = b;
        if (m == MODE_512) r[127:0]   = l;
        else               r[575:512] = l[63:0];
        return r;
    endfunction

    assign in_ready   = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign w_accept   = in_valid & in_ready;
    assign w_cur_mode = (r_state == ST_IDLE) ? in_mode : r_mode;
    assign w_cur_word = in_last ? w_masked : in_data;
    assign w_widx_inc = r_widx + c_widx_w'(1);
    assign w_at_end   = (r_widx == c_widx_w'(blk_bytes(w_cur_mode) / c_wb - 1));
    assign w_used     = 10'(r_widx) * 10'(c_wb) + 10'(in_bytes) + 10'd1;
    assign w_fits     = (w_used <= 10'(fit_bytes(w_cur_mode)));

    assign w_len_base  = (r_state == ST_IDLE) ? '0 : r_len;
    assign w_len_add   = in_last ? (LEN_W'(in_bytes) << 3) : LEN_W'(c_wb * 8);
    assign w_len_sum   = w_len_base + w_len_add;
    assign w_field_src = (r_state == ST_EXTRA) ? r_len : w_len_sum;

    generate
        if (LEN_W >= 128) begin : g_field_wide
            assign w_len_field = w_field_src[127:0];
        end else begin : g_field_narrow
            assign w_len_field = {{(128-LEN_W){1'b0}}, w_field_src};
        end
    endgenerate

    // Words land in the top half for mode 0, so both modes share one layout.
    always_comb begin
        w_buf_word = r_buf;
        for (int i = 0; i < c_max_words; i++) begin
            if (c_widx_w'(i) == r_widx)
                w_buf_word[1023-i*WORD_W -: WORD_W] = w_cur_word;
            if (in_last && w_spill && !w_at_end && (c_widx_w'(i) == w_widx_inc))
                w_buf_word[1023-i*WORD_W -: 8] = 8'h80;
        end
    end

    assign w_buf_extra = {(r_marker_pend ? 8'h80 : 8'h00), 1016'b0};

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_widx_nxt   = r_widx;
        w_len_nxt    = r_len;
        w_mode_nxt   = r_mode;
        w_last_nxt   = r_blk_last;
        w_extra_nxt  = r_extra_pend;
        w_marker_nxt = r_marker_pend;

        case (r_state)
            ST_IDLE, ST_FILL: begin
                if (w_accept) begin
                    w_mode_nxt = w_cur_mode;
                    w_len_nxt  = w_len_sum;
                    w_buf_nxt  = w_buf_word;
                    if (in_last) begin
                        w_state_nxt = ST_OUT;
                        if (w_fits) begin
                            w_buf_nxt  = put_len(w_buf_word, w_cur_mode, w_len_field);
                            w_last_nxt = 1'b1;
                        end else begin
                            w_last_nxt   = 1'b0;
                            w_extra_nxt  = 1'b1;
                            w_marker_nxt = w_spill & w_at_end;
                        end
                    end else if (w_at_end) begin
                        w_state_nxt = ST_OUT;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_FILL;
                        w_widx_nxt  = w_widx_inc;
                    end
                end
            end
            ST_OUT: begin
                if (blk_ready) begin
                    if (r_blk_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_buf_nxt    = '0;
                        w_widx_nxt   = '0;
                        w_len_nxt    = '0;
                        w_mode_nxt   = 1'b0;
                        w_last_nxt   = 1'b0;
                        w_extra_nxt  = 1'b0;
                        w_marker_nxt = 1'b0;
                    end else if (r_extra_pend) begin
                        w_state_nxt = ST_EXTRA;
                    end else begin
                        w_state_nxt = ST_FILL;
                        w_buf_nxt   = '0;
                        w_widx_nxt  = '0;
                    end
                end
            end
            ST_EXTRA: begin
                w_buf_nxt    = put_len(w_buf_extra, r_mode, w_len_field);
                w_last_nxt   = 1'b1;
                w_extra_nxt  = 1'b0;
                w_marker_nxt = 1'b0;
                w_state_nxt  = ST_OUT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Abort wins over everything, including a pending block.
        if (clr) begin
            w_state_nxt  = ST_IDLE;
            w_buf_nxt    = '0;
            w_widx_nxt   = '0;
            w_len_nxt    = '0;
            w_mode_nxt   = 1'b0;
            w_last_nxt   = 1'b0;
            w_extra_nxt  = 1'b0;
            w_marker_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_buf         <= '0;
            r_widx        <= '0;
            r_len         <= '0;
            r_mode        <= 1'b0;
            r_blk_last    <= 1'b0;
            r_extra_pend  <= 1'b0;
            r_marker_pend <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_buf         <= w_buf_nxt;
            r_widx        <= w_widx_nxt;
            r_len         <= w_len_nxt;
            r_mode        <= w_mode_nxt;
            r_blk_last    <= w_last_nxt;
            r_extra_pend  <= w_extra_nxt;
            r_marker_pend <= w_marker_nxt;
        end
    end

    assign blk_valid = (r_state == ST_OUT);
    assign blk_last  = blk_valid & r_blk_last;
    assign blk_mode  = r_mode;
    assign blk_data  = (r_mode == MODE_512) ? r_buf : {512'b0, r_buf[1023:512]};

`ifdef SHA_PAD_OVF_EN
    logic r_len_ovf;
    logic w_len_wrap;
    logic w_len_hi;
    logic w_ovf_hit;

    assign w_len_wrap = (w_len_sum < w_len_base);

    generate
        if (LEN_W > 64) begin : g_ovf_hi
            assign w_len_hi = |w_len_sum[LEN_W-1:64];
        end else begin : g_ovf_nohi
            assign w_len_hi = 1'b0;
        end
    endgenerate

    assign w_ovf_hit = w_len_wrap | ((w_cur_mode == MODE_256) & w_len_hi);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_ovf <= 1'b0;
        end else if (clr) begin
            r_len_ovf <= 1'b0;
        end else if (w_accept) begin
            r_len_ovf <= ((r_state == ST_IDLE) ? 1'b0 : r_len_ovf) | w_ovf_hit;
        end
    end

    assign len_ovf = r_len_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sha_msg_padder.sv
// ============================================================================
//  Module      : tb_sha_msg_padder
//  Description : Directed, table-driven bench for sha_msg_padder.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha_msg_padder;

    localparam int WORD_W = 64;
    localparam int WB     = WORD_W / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               clr;
    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic [3:0]         in_bytes;
    logic               in_mode;
    logic               blk_valid;
    logic               blk_ready;
    logic [1023:0]      blk_data;
    logic               blk_last;
    logic               blk_mode;
`ifdef SHA_PAD_OVF_EN
    logic               len_ovf;
`endif

    int errors = 0;
    int checks = 0;
    logic [1023:0] last_blk;

    typedef struct {
        logic         mode;
        int           nbytes;
        int           nblk;
        logic [127:0] exp_len;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    sha_msg_padder #(
        .WORD_W (WORD_W),
        .LEN_W  (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .in_mode   (in_mode),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .blk_mode  (blk_mode)
`ifdef SHA_PAD_OVF_EN
        ,
        .len_ovf   (len_ovf)
`endif
    );

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int k);
        return 8'(32'h61 + k);
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, " in_ready"},  1024'(in_ready),  1024'(1));
        check({name, " blk_valid"}, 1024'(blk_valid), 1024'(0));
        check({name, " blk_data"},  blk_data,         1024'(0));
        check({name, " blk_last"},  1024'(blk_last),  1024'(0));
        check({name, " blk_mode"},  1024'(blk_mode),  1024'(0));
    endtask

    // Drives one message and checks every block against an independently built padded image.
    task automatic run_msg(input string name, input logic mode, input int nbytes,
                           input int nblk, input int hold_cycles);
        int            blen;
        int            llen;
        int            nwords;
        int            w;
        int            b;
        int            cyc;
        int            hold;
        logic [7:0]    pad [0:383];
        logic [127:0]  bitlen;
        logic [1023:0] tmp;
        logic [1023:0] held;
        blen   = mode ? 128 : 64;
        llen   = mode ? 16 : 8;
        nwords = (nbytes == 0) ? 1 : (nbytes + WB - 1) / WB;
        w = 0; b = 0; cyc = 0; hold = hold_cycles; held = '0;
        for (int i = 0; i < 384; i++) pad[i] = 8'h00;
        for (int i = 0; i < nbytes; i++) pad[i] = msg_byte(i);
        pad[nbytes] = 8'h80;
        bitlen = 128'(nbytes) * 128'd8;
        for (int i = 0; i < llen; i++) pad[nblk*blen-1-i] = bitlen[8*i +: 8];

        while (b < nblk && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (w < nwords) begin
                in_valid = 1'b1;
                in_mode  = (w == 0) ? mode : ~mode;
                in_last  = (w == nwords - 1);
                in_bytes = in_last ? 4'(nbytes - WB*(nwords-1)) : 4'd3;
                for (int j = 0; j < WB; j++)
                    in_data[WORD_W-1-8*j -: 8] = (WB*w+j < nbytes) ? msg_byte(WB*w+j) : 8'hA5;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            blk_ready = (hold == 0);
            if (blk_valid) begin
                if (hold > 0) begin
                    if (hold == hold_cycles) held = blk_data;
                    else check($sformatf("%s hold data", name), blk_data, held);
                    check($sformatf("%s hold in_ready", name), 1024'(in_ready), 1024'(0));
                    hold--;
                end else begin
                    tmp = '0;
                    for (int j = 0; j < blen; j++) tmp[1023-8*j -: 8] = pad[b*blen+j];
                    if (!mode) tmp = tmp >> 512;
                    check($sformatf("%s blk%0d data", name, b), blk_data, tmp);
                    check($sformatf("%s blk%0d last", name, b), 1024'(blk_last), 1024'(b == nblk-1));
                    check($sformatf("%s blk%0d mode", name, b), 1024'(blk_mode), 1024'(mode));
                    last_blk = blk_data;
                    b++;
                end
            end
            if (in_valid && in_ready) w++;
        end
        if (b < nblk) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d blocks expected %0d", name, b, nblk);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        blk_ready = 1'b1;
        check($sformatf("%s idle in_ready", name), 1024'(in_ready), 1024'(1));
        check($sformatf("%s idle blk_valid", name), 1024'(blk_valid), 1024'(0));
    endtask

    initial begin
        vecs[0]  = '{1'b0,   3, 1, 128'h18};
        vecs[1]  = '{1'b0,  55, 1, 128'h1B8};
        vecs[2]  = '{1'b0,  56, 2, 128'h1C0};
        vecs[3]  = '{1'b0,  64, 2, 128'h200};
        vecs[4]  = '{1'b0,   0, 1, 128'h0};
        vecs[5]  = '{1'b0, 119, 2, 128'h3B8};
        vecs[6]  = '{1'b0, 120, 3, 128'h3C0};
        vecs[7]  = '{1'b1, 128, 2, 128'h400};
        vecs[8]  = '{1'b1,   0, 1, 128'h0};
        vecs[9]  = '{1'b1, 111, 1, 128'h378};
        vecs[10] = '{1'b1, 112, 2, 128'h380};
        vecs[11] = '{1'b1, 200, 2, 128'h640};
        vecs[12] = '{1'b1,  17, 1, 128'h88};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_bytes = '0; in_mode = 1'b0; blk_ready = 1'b1; last_blk = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        for (int v = 0; v < 13; v++) begin
            run_msg($sformatf("vec%0d", v), vecs[v].mode, vecs[v].nbytes, vecs[v].nblk, 0);
            check($sformatf("vec%0d length", v),
                  vecs[v].mode ? 1024'(last_blk[127:0]) : 1024'(last_blk[63:0]),
                  1024'(vecs[v].exp_len));
        end

        run_msg("abc", 1'b0, 3, 1, 0);
        check("abc head", 1024'(last_blk[511:480]), 1024'(32'h61626380));
        check("abc tail", 1024'(last_blk[63:0]), 1024'(64'h18));

        run_msg("b56", 1'b0, 56, 2, 0);
        check("b56 blk1 zeros", 1024'(last_blk[511:64]), 1024'(0));

        run_msg("b128", 1'b1, 128, 2, 0);
        check("b128 blk1", last_blk, {8'h80, 888'b0, 128'h400});

        run_msg("empty1", 1'b1, 0, 1, 0);
        check("empty1 blk", last_blk, {8'h80, 1016'b0});

        run_msg("hold", 1'b0, 100, 2, 10);
        run_msg("after_hold", 1'b1, 40, 1, 0);

        // Asynchronous reset in the middle of a mode-1 fill.
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_last = 1'b0; in_bytes = 4'd0;
        in_data = 64'h0123456789ABCDEF;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid_fill");
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        run_msg("after_rst", 1'b0, 21, 1, 0);

        // Synchronous abort while a full block is waiting.
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b0; in_last = 1'b0; in_bytes = 4'd0; blk_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_data = {8{8'(k + 1)}};
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("clr pre blk_valid", 1024'(blk_valid), 1024'(1));
        clr = 1'b1;
        @(negedge clk);
        check_reset_outputs("clr_in_out");
        clr = 1'b0;
        blk_ready = 1'b1;
        run_msg("after_clr", 1'b0, 60, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
